alu_execute: RTL and testbench
==============================

# alu_execute

Execute-stage ALU that consumes the 2-bit `aluCtrl` code produced by the decode-stage ALU control, together with the decoded operands and destination register. It performs ADD/SUB/AND in one cycle and MUL as an iterative 32-cycle shift-add operation. Results are registered and delivered to the memory stage over a valid/ready handshake. Back-pressure from the memory stage stalls decode through `in_ready`.

## Interface
- No parameters. Datapath is fixed at 32 bits and the register index is 5 bits.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decode presents an operation.
- `in_ready` out 1: execute accepts the operation this cycle.
- `aluCtrl` in 2: operation code. 00 = ADD, 01 = SUB, 10 = MUL, 11 = AND.
- `srcA` in 32: operand A.
- `srcB` in 32: operand B.
- `destReg` in 5: destination register index, passed through unchanged.
- `out_valid` out 1: a result is held for the memory stage.
- `out_ready` in 1: the memory stage takes the result.
- `result` out 32: the ALU result.
- `out_destReg` out 5: `destReg` of the operation that produced `result`.
- `zero` out 1: high when `result` == 0.
- `illegal` out 1: high when the held result came from an unsupported code.

## Operation
- Accept condition: an operation is accepted at a rising edge when `in_valid && in_ready`.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready). This is combinational.
- States:
  - **IDLE**
    - Accepting ADD, SUB or AND writes `result`, `out_destReg`, `zero` and `illegal` = 0, and sets `out_valid`. The state stays IDLE.
    - Accepting MUL latches the operands and `destReg`, clears the accumulator, sets the counter to 0 and moves to MUL_BUSY.
  - **MUL_BUSY**
    - Each cycle: if bit `count` of multiplier B is set, add A << `count` to the accumulator, keeping the low 32 bits. Then increment `count`.
    - When `count` == 31 is processed, load `result`, `zero` and `out_destReg`, set `out_valid` and return to IDLE.
- Output hold: while `out_valid && !out_ready`, the values of `result`, `out_destReg`, `zero` and `illegal` are held unchanged.
- Output clear: when `out_valid && out_ready` and no new result is loaded on the same edge, `out_valid` goes to 0.
- Simultaneous drain and accept: a single-cycle operation accepted on the same edge as the drain loads the new result, and `out_valid` stays 1.
- Simultaneous drain and MUL accept: `out_valid` drops to 0 and the MUL proceeds.
- Arithmetic: ADD and SUB wrap modulo 2^32. MUL keeps the low 32 bits, unsigned, which gives identical low bits for signed operands. No overflow or carry flags exist.
- `in_valid` is ignored while in MUL_BUSY, because `in_ready` is 0 there.

## Timing
- Reset values: all outputs are 0 (`out_valid`, `result`, `out_destReg`, `zero`, `illegal`). The state is IDLE and the counter is 0.
- Reset mid-operation: asserting `reset_n` during MUL_BUSY aborts the multiply immediately, and no result is produced.
- Latency of ADD, SUB and AND, with acceptance at edge E0: `out_valid` is high after E0, i.e. 1 cycle.
- Latency of MUL, with acceptance at E0: iterations run at E1..E32, and `out_valid` is high after E32, i.e. 33 cycles. `in_ready` is 0 from after E0 through E32.
- Throughput: one single-cycle operation per clock when `out_ready` is held high.

## Configuration
- `ALU_MUL_EN` defined:
  - The MUL_BUSY state and the multiplier datapath are compiled in.
  - `aluCtrl` = 10 behaves as described above.
- `ALU_MUL_EN` not defined:
  - No MUL_BUSY state, no counter and no accumulator are built.
  - `aluCtrl` = 10 is treated as a single-cycle operation with `result` = 0, `zero` = 1 and `illegal` = 1, at latency 1.
  - `in_ready` reduces to !out_valid || out_ready.

## Test plan
- **Reset:** `reset_n` = 0 with random inputs -> all outputs 0 and `in_ready` = 1.
- **ADD/SUB/AND:** ADD 5 + 7, then SUB 3 - 5, then AND 0xF0F0 & 0x0FF0.
  - `out_ready` high throughout.
  - Expect 12, then 0xFFFFFFFE, then 0x00F0 on consecutive cycles, each 1 cycle after acceptance, with `destReg` passed through.
- **Back-pressure:** hold `out_ready` = 0 for 4 cycles after ADD 1 + 2.
  - `result` = 3 is held stable and `in_ready` = 0.
  - Raise `out_ready` while SUB 9 - 9 is pending: it is accepted on the same edge, then `result` = 0 with `zero` = 1.
- **MUL (`ALU_MUL_EN`):** 0x0001_0001 × 0x0001_0003.
  - `in_ready` = 0 for 32 cycles.
  - Result is 0x0004_0003 exactly 33 cycles after acceptance.
  - 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000001.
- **Reset mid-MUL:** pulse `reset_n` low at iteration 10 -> `out_valid` never rises for that MUL, and the next ADD 2 + 2 returns 4 at latency 1.
- **MUL disabled (no `ALU_MUL_EN`):** `aluCtrl` = 10 with 6 × 7 -> `result` 0, `zero` 1, `illegal` 1 at latency 1.

Source files
------------

// File: rtl/alu_execute.sv
// ---------------------------------------------------------------------------
// alu_execute : execute-stage ALU (ADD/SUB/AND single-cycle, optional iterative
// MUL built only when ALU_MUL_EN is defined), valid/ready output.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_execute (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  aluCtrl,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [4:0]  destReg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  out_destReg,
  output logic        zero,
  output logic        illegal
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  out_dest_q, out_dest_d;
  logic        zero_q, zero_d;
  logic        illegal_q, illegal_d;

  logic        accept;
  logic        drain;
  logic        single_op;
  logic [31:0] alu_res;
  logic        alu_ill;

`ifdef ALU_MUL_EN
  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  mdest_q, mdest_d;
  logic [31:0] acc_sum;

  // Multiplicand shifts left and multiplier right, so bit 0 of the
  // multiplier always holds original bit 'count'.
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign single_op = (aluCtrl != OP_MUL);
`else
  assign in_ready  = !out_valid_q || out_ready;
  assign single_op = 1'b1;
`endif

  assign accept = in_valid && in_ready;
  assign drain  = out_valid_q && out_ready;

  always_comb begin
    alu_res = 32'd0;
    alu_ill = 1'b0;
    case (aluCtrl)
      OP_ADD:  alu_res = srcA + srcB;
      OP_SUB:  alu_res = srcA - srcB;
      OP_AND:  alu_res = srcA & srcB;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_dest_d  = out_dest_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;

    if (drain) begin
      out_valid_d = 1'b0;
    end

    if (accept && single_op) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      out_dest_d  = destReg;
      zero_d      = (alu_res == 32'd0);
      illegal_d   = alu_ill;
    end

`ifdef ALU_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mdest_d  = mdest_q;

    case (state_q)
      S_IDLE: begin
        if (accept && !single_op) begin
          mcand_d  = srcA;
          mplier_d = srcB;
          acc_d    = 32'd0;
          cnt_d    = 5'd0;
          mdest_d  = destReg;
          state_d  = S_MUL_BUSY;
        end
      end
      S_MUL_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          out_valid_d = 1'b1;
          result_d    = acc_sum;
          out_dest_d  = mdest_q;
          zero_d      = (acc_sum == 32'd0);
          illegal_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      out_dest_q  <= 5'd0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= S_IDLE;
      mcand_q     <= 32'd0;
      mplier_q    <= 32'd0;
      acc_q       <= 32'd0;
      cnt_q       <= 5'd0;
      mdest_q     <= 5'd0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_dest_q  <= out_dest_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mdest_q     <= mdest_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign out_destReg = out_dest_q;
  assign zero        = zero_q;
  assign illegal     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_execute.sv
// ---------------------------------------------------------------------------
// tb_alu_execute : directed vector bench for alu_execute.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_execute;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  aluCtrl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [4:0]  destReg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_destReg;
  logic        zero;
  logic        illegal;

  int n_pass = 0;
  int n_total = 0;

  alu_execute dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .aluCtrl     (aluCtrl),
    .srcA        (srcA),
    .srcB        (srcB),
    .destReg     (destReg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .out_destReg (out_destReg),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d);
    in_valid = v;
    aluCtrl  = op;
    srcA     = a;
    srcB     = b;
    destReg  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef ALU_MUL_EN
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic [4:0] d);
    int busy_cycles;
    int early_valid;
    busy_cycles = 0;
    early_valid = 0;
    @(negedge clk);
    drive(1'b1, 2'b10, a, b, d);
    out_ready = 1'b1;
    #1;
    chk("mul_accept_ready", {31'd0, in_ready}, 32'd1);
    tick();
    // An ADD held on the inputs while busy must be ignored.
    @(negedge clk);
    drive(1'b1, 2'b00, 32'd100, 32'd200, 5'd1);
    for (int k = 1; k <= 32; k++) begin
      #1;
      if (!in_ready) busy_cycles++;
      if (out_valid) early_valid++;
      @(posedge clk);
      if (k < 32) @(negedge clk);
    end
    #1;
    chk("mul_busy_cycles", busy_cycles, 32'd32);
    chk("mul_no_early_valid", early_valid, 32'd0);
    chk("mul_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_result", result, exp);
    chk("mul_dest", {27'd0, out_destReg}, {27'd0, d});
    chk("mul_zero", {31'd0, zero}, {31'd0, (exp == 32'd0)});
    chk("mul_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    chk("mul_drained", {31'd0, out_valid}, 32'd0);
  endtask
`endif

  initial begin
    int seen_valid;

    vecs[0] = '{2'b00, 32'd5,          32'd7,          5'd3,  32'd12,         1'b0};
    vecs[1] = '{2'b01, 32'd3,          32'd5,          5'd4,  32'hFFFF_FFFE,  1'b0};
    vecs[2] = '{2'b11, 32'h0000_F0F0,  32'h0000_0FF0,  5'd5,  32'h0000_00F0,  1'b0};
    vecs[3] = '{2'b00, 32'hFFFF_FFFF,  32'd1,          5'd6,  32'd0,          1'b1};
    vecs[4] = '{2'b01, 32'd9,          32'd9,          5'd31, 32'd0,          1'b1};
    vecs[5] = '{2'b11, 32'hFFFF_0000,  32'h0000_FFFF,  5'd0,  32'd0,          1'b1};
    vecs[6] = '{2'b00, 32'h7FFF_FFFF,  32'd1,          5'd17, 32'h8000_0000,  1'b0};

    // Reset with arbitrary inputs toggling.
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    repeat (3) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dest", {27'd0, out_destReg}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);

    // Back-to-back single-cycle ops with the sink always ready.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest);
      #1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].res);
      chk($sformatf("vec%0d_dest", i), {27'd0, out_destReg}, {27'd0, vecs[i].dest});
      chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
      chk($sformatf("vec%0d_illegal", i), {31'd0, illegal}, 32'd0);
    end

    // Back-pressure: ADD 1+2 held while the sink stalls, SUB waits.
    @(negedge clk);
    drive(1'b1, 2'b00, 32'd1, 32'd2, 5'd7);
    tick();
    chk("bp_add_result", result, 32'd3);
    @(negedge clk);
    drive(1'b1, 2'b01, 32'd9, 32'd9, 5'd8);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp_in_ready_%0d", c), {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("bp_hold_%0d", c),
          {out_valid, zero, illegal, out_destReg, 24'd0} | {8'd0, result[23:0]},
          {1'b1, 1'b0, 1'b0, 5'd7, 24'd3});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_sub_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_sub_result", result, 32'd0);
    chk("bp_sub_zero", {31'd0, zero}, 32'd1);
    chk("bp_sub_dest", {27'd0, out_destReg}, 32'd8);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    chk("bp_clear", {31'd0, out_valid}, 32'd0);

`ifdef ALU_MUL_EN
    do_mul(32'h0001_0001, 32'h0001_0003, 32'h0004_0003, 5'd11);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5'd12);

    // Abort a multiply with reset after ten iterations.
    @(negedge clk);
    drive(1'b1, 2'b10, 32'd123, 32'd456, 5'd13);
    tick();
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    chk("abort_no_result", seen_valid, 32'd0);
`else
    @(negedge clk);
    drive(1'b1, 2'b10, 32'd6, 32'd7, 5'd10);
    tick();
    chk("nomul_valid", {31'd0, out_valid}, 32'd1);
    chk("nomul_result", result, 32'd0);
    chk("nomul_zero", {31'd0, zero}, 32'd1);
    chk("nomul_illegal", {31'd0, illegal}, 32'd1);
    chk("nomul_dest", {27'd0, out_destReg}, 32'd10);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    seen_valid = out_valid ? 1 : 0;
    chk("nomul_clear", seen_valid, 32'd0);
`endif

    // Single-cycle op after the preceding sequence.
    @(negedge clk);
    drive(1'b1, 2'b00, 32'd2, 32'd2, 5'd9);
    tick();
    chk("post_add_valid", {31'd0, out_valid}, 32'd1);
    chk("post_add_result", result, 32'd4);
    chk("post_add_dest", {27'd0, out_destReg}, 32'd9);
    chk("post_add_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
